spi_feeder: RTL and testbench
=============================

SPI_FEEDER -- requirements
Module: spi_feeder

Interface
REQ-001 SHALL have parameter BITS, default 8: width of one SPI word.
REQ-002 SHALL have parameter DEPTH, default 4: transmit queue entries, power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 64: cycles allowed per transfer before error.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, BITS: word offered by the producer.
REQ-007 SHALL have port in_valid, input, 1: producer offers in_data.
REQ-008 SHALL have port in_ready, output, 1: queue can accept a word.
REQ-009 SHALL have port m_data_out, output, BITS: word presented to the SPI master.
REQ-010 SHALL have port m_data_ready, output, 1: request to the master to start a transfer.
REQ-011 SHALL have port m_data_sent, input, 1: master reports the transfer is complete.
REQ-012 SHALL have port m_data_in, input, BITS: word shifted in by the master.
REQ-013 SHALL have port rx_data, output, BITS: captured received word.
REQ-014 SHALL have port rx_valid, output, 1: one-cycle strobe qualifying rx_data.
REQ-015 SHALL have port busy, output, 1: high when the FSM is not in IDLE or the queue is not empty.
REQ-016 SHALL have port err, output, 1: sticky timeout flag.

Function
REQ-017 SHALL write in_data into the queue on any cycle where in_valid and in_ready are both high; in_ready = not full.
REQ-018 SHALL run a four-state FSM: IDLE -> LOAD -> WAIT_DONE -> CAPTURE -> IDLE.
REQ-019 In IDLE with the queue non-empty, SHALL pop the head word into the output register and go to LOAD next cycle.
REQ-020 In LOAD, SHALL drive m_data_out with the popped word, assert m_data_ready, clear the timeout counter, and go to WAIT_DONE.
REQ-021 In WAIT_DONE, SHALL hold m_data_ready and m_data_out stable until m_data_sent is sampled high, then go to CAPTURE.
REQ-022 In CAPTURE, SHALL deassert m_data_ready, load rx_data from m_data_in, pulse rx_valid for exactly one cycle, and return to IDLE.
REQ-023 Latency SHALL be: queue write to m_data_ready high = 2 cycles when IDLE and empty; m_data_sent high to rx_valid = 1 cycle.
REQ-024 A push and a pop in the same cycle SHALL both succeed; a push at full SHALL be ignored and in_ready SHALL stay low.
REQ-025 Queue pointers SHALL be log2(DEPTH) bits plus one wrap bit; full and empty SHALL be exact at wrap-around.
REQ-026 If m_data_sent is already high on entry to WAIT_DONE, SHALL advance to CAPTURE on the next cycle.
REQ-027 If WAIT_DONE lasts TIMEOUT cycles, SHALL set err, drop m_data_ready, discard the word without an rx_valid pulse, and return to IDLE.
REQ-028 err SHALL clear only on rst.

Reset
REQ-029 On rst SHALL empty the queue and set: FSM = IDLE; m_data_ready, rx_valid, err = 0; m_data_out, rx_data = 0; in_ready = 1.
REQ-030 rst asserted mid-transfer SHALL abandon the transfer immediately, with no rx_valid pulse.

Configuration
REQ-031 With macro SPI_FEEDER_RX_CAPTURE_EN defined, SHALL implement rx_data and rx_valid as in REQ-022.
REQ-032 Without SPI_FEEDER_RX_CAPTURE_EN, rx_data and rx_valid SHALL be tied to 0, m_data_in SHALL be unused, and CAPTURE SHALL still last one cycle.

Structure
REQ-033 Package spi_feeder_pkg SHALL hold the FSM state enum (IDLE, LOAD, WAIT_DONE, CAPTURE) and default parameter constants.
REQ-034 The queue SHALL be a separate sub-module spi_feeder_fifo (BITS, DEPTH) exposing push, pop, full, empty and head data.

Verification
REQ-035 Single word: push 0xA5; master model raises m_data_sent 20 cycles after m_data_ready with m_data_in = 0x3C -> m_data_out = 0xA5 2 cycles after the push; one rx_valid with rx_data = 0x3C.
REQ-036 Fill: push 5 words (DEPTH = 4) while the master stalls -> in_ready low after the 4th accepted word and the 5th word is dropped; 4 transfers complete in order.
REQ-037 Timeout: master never responds -> err high at TIMEOUT + 2 cycles after the push, m_data_ready low, no rx_valid, next queued word still sent.
REQ-038 Reset mid-transfer: assert rst during WAIT_DONE -> next cycle all outputs match reset values and the queue is empty.
REQ-039 Simultaneous push/pop at full: push in the same cycle IDLE pops -> word accepted, count unchanged, order preserved across pointer wrap.
REQ-040 Macro off: rebuild without SPI_FEEDER_RX_CAPTURE_EN and repeat REQ-035 -> rx_valid never asserts and transfer timing is identical.

Source files
------------

// File: rtl/spi_feeder_pkg.sv
// spi_feeder shared types and default parameters.
// Optional RX capture is enabled with SPI_FEEDER_RX_CAPTURE_EN.
package spi_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_DONE,
      CAPTURE
   } state_t;

   localparam int DEF_BITS    = 8;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_TIMEOUT = 64;

   // Width of a counter that must hold the value n.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/spi_feeder_fifo.sv
// spi_feeder transmit queue: DEPTH x BITS, wrap-bit pointers.
// A pop frees a slot in the same cycle, so push at full succeeds with pop.
module spi_feeder_fifo
   import spi_feeder_pkg::*;
#(
   parameter int BITS  = DEF_BITS,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [BITS-1:0] wdata,
   input  logic            pop,
   output logic [BITS-1:0] head,
   output logic            full,
   output logic            empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [BITS-1:0] mem [DEPTH];
   logic            do_push;
   logic            do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer advance; reset empties the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/spi_feeder.sv
// spi_feeder: queues words and hands them one at a time to an SPI master.
// Define SPI_FEEDER_RX_CAPTURE_EN to capture the received word on rx_data.
module spi_feeder
   import spi_feeder_pkg::*;
#(
   parameter int BITS    = DEF_BITS,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [BITS-1:0] m_data_out,
   output logic            m_data_ready,
   input  logic            m_data_sent,
   input  logic [BITS-1:0] m_data_in,
   output logic [BITS-1:0] rx_data,
   output logic            rx_valid,
   output logic            busy,
   output logic            err
);

   localparam int TW = cnt_w(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1);

   state_t          state;
   state_t          state_nx;
   logic [TW-1:0]   to_cnt;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [BITS-1:0] fifo_head;
   logic            done;
   logic            timed_out;

   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   // A slot freed by this cycle's pop is offered straight back.
   assign in_ready  = !fifo_full || fifo_pop;
   assign fifo_push = in_valid && in_ready;
   assign busy      = (state != IDLE) || !fifo_empty;
   assign done      = (state == WAIT_DONE) && m_data_sent;
   assign timed_out = (state == WAIT_DONE) && !m_data_sent &&
                      (to_cnt == TO_LAST);

   spi_feeder_fifo #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (in_data),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Transfer sequencing; completion beats timeout in the same cycle.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      if (!fifo_empty) state_nx = LOAD;
         LOAD:      state_nx = WAIT_DONE;
         WAIT_DONE: begin
            if (m_data_sent)    state_nx = CAPTURE;
            else if (timed_out) state_nx = IDLE;
         end
         CAPTURE:   state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Master-side outputs, timeout counter and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_data_out   <= '0;
         m_data_ready <= 1'b0;
         to_cnt       <= '0;
         err          <= 1'b0;
      end else begin
         if (fifo_pop) m_data_out <= fifo_head;
         if (state == LOAD) begin
            m_data_ready <= 1'b1;
            to_cnt       <= '0;
         end
         if (state == WAIT_DONE) begin
            if (done || timed_out) m_data_ready <= 1'b0;
            else                   to_cnt <= to_cnt + TO_ONE;
         end
         if (timed_out) err <= 1'b1;
      end
   end

`ifdef SPI_FEEDER_RX_CAPTURE_EN
   // Capture the master's word as the FSM enters CAPTURE.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= done;
         if (done) rx_data <= m_data_in;
      end
   end
`else
   logic unused_rx;
   assign unused_rx = ^m_data_in;
   assign rx_data   = '0;
   assign rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_feeder.sv
// Self-checking bench for spi_feeder with a scoreboarded master model.
// Expects rx captures only when SPI_FEEDER_RX_CAPTURE_EN is defined.
`timescale 1ns/1ps
module tb_spi_feeder;

   localparam int BITS    = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
`ifdef SPI_FEEDER_RX_CAPTURE_EN
   localparam bit RXEN = 1'b1;
`else
   localparam bit RXEN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [BITS-1:0] in_data;
   logic            in_valid;
   logic            in_ready;
   logic [BITS-1:0] m_data_out;
   logic            m_data_ready;
   logic            m_data_sent;
   logic [BITS-1:0] m_data_in;
   logic [BITS-1:0] rx_data;
   logic            rx_valid;
   logic            busy;
   logic            err;

   always #5 clk = ~clk;

   spi_feeder #(
      .BITS    (BITS),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .m_data_out   (m_data_out),
      .m_data_ready (m_data_ready),
      .m_data_sent  (m_data_sent),
      .m_data_in    (m_data_in),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .busy         (busy),
      .err          (err)
   );

   int n_chk = 0;
   int n_err = 0;
   logic [BITS-1:0] tx_q[$];
   logic [BITS-1:0] rx_q[$];
   int master_delay = 20;
   bit master_hold  = 1'b0;
   bit master_mute  = 1'b0;
   logic [BITS-1:0] rx_word = 8'h3C;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [BITS-1:0] d, output bit acc);
      in_valid = 1'b1;
      in_data  = d;
      acc      = in_ready;
      if (acc) tx_q.push_back(d);
      @(posedge clk);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_rdy(input string tag);
      int i = 0;
      while (!m_data_ready && i < 20) begin
         step();
         i++;
      end
      chk(tag, m_data_ready, 1);
   endtask

   task automatic wait_idle(input string tag);
      int i = 0;
      while (busy && i < 2000) begin
         step();
         i++;
      end
      chk(tag, busy, 0);
   endtask

   // Master model: answers each request after master_delay cycles.
   initial begin : master
      int wcnt;
      m_data_sent = 1'b0;
      m_data_in   = '0;
      wcnt        = 0;
      forever begin
         @(negedge clk);
         if (rst || !m_data_ready) begin
            m_data_sent = 1'b0;
            wcnt        = 0;
         end else if (!master_mute && !master_hold && !m_data_sent) begin
            wcnt++;
            if (wcnt >= master_delay) begin
               m_data_sent = 1'b1;
               m_data_in   = rx_word;
               if (RXEN) rx_q.push_back(rx_word);
               rx_word = rx_word + 8'h11;
            end
         end
      end
   end

   // Scoreboard: tx order on each new request, rx data on each strobe.
   initial begin : monitor
      bit rdy_q;
      rdy_q = 1'b0;
      forever begin
         step();
         if (m_data_ready && !rdy_q) begin
            if (tx_q.size() == 0) chk("tx_unexp", tx_q.size(), 1);
            else chk("tx_order", m_data_out, tx_q.pop_front());
         end
         rdy_q = m_data_ready;
         if (rx_valid) begin
            if (rx_q.size() == 0) chk("rx_unexp", rx_valid, 0);
            else chk("rx_data", rx_data, rx_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #400000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin : main
      bit acc;
      int i;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_m_rdy", m_data_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dout", m_data_out, 0);
      chk("rst_rx_data", rx_data, 0);
      rst = 1'b0;
      step();

      // Single word, 20-cycle master.
      master_delay = 20;
      push(8'hA5, acc);
      chk("sw_acc", acc, 1);
      step();
      chk("sw_load_rdy", m_data_ready, 0);
      chk("sw_load_busy", busy, 1);
      step();
      chk("sw_rdy", m_data_ready, 1);
      chk("sw_dout", m_data_out, 8'hA5);
      i = 0;
      while (!m_data_sent && i < 60) begin
         step();
         i++;
      end
      chk("sw_sent", m_data_sent, 1);
      chk("sw_hold_rdy", m_data_ready, 1);
      chk("sw_hold_dout", m_data_out, 8'hA5);
      step();
      chk("sw_rx_valid", rx_valid, RXEN);
      chk("sw_rx_data", rx_data, RXEN ? 8'h3C : 8'h00);
      chk("sw_cap_rdy", m_data_ready, 0);
      step();
      chk("sw_rx_pulse", rx_valid, 0);
      chk("sw_idle", busy, 0);

      // Fill while the master stalls, then push during the full-queue pop.
      master_hold = 1'b1;
      master_delay = 3;
      push(8'h11, acc);
      wait_rdy("fill_start");
      for (int k = 0; k < 5; k++) begin
         push(8'h21 + 8'(k), acc);
         chk($sformatf("fill_acc%0d", k), acc, (k < 4));
      end
      chk("fill_rdy_low", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 8'h26;
      master_hold = 1'b0;
      acc = 1'b0;
      i = 0;
      while (!acc && i < 20) begin
         if (in_ready) begin
            acc = 1'b1;
            tx_q.push_back(8'h26);
            @(posedge clk);
         end
         step();
         i++;
      end
      in_valid = 1'b0;
      chk("swap_acc", acc, 1);
      chk("swap_full", in_ready, 0);
      wait_idle("fill_done");
      chk("fill_txq", tx_q.size(), 0);

      // Timeout: master silent for the first word only.
      master_mute = 1'b1;
      master_delay = 4;
      push(8'h5A, acc);
      push(8'h6B, acc);
      repeat (TIMEOUT) step();
      chk("to_err_early", err, 0);
      chk("to_rdy_early", m_data_ready, 1);
      step();
      chk("to_err", err, 1);
      chk("to_rdy_drop", m_data_ready, 0);
      chk("to_no_rx", rx_valid, 0);
      master_mute = 1'b0;
      wait_idle("to_next_done");
      chk("to_txq", tx_q.size(), 0);
      chk("to_sticky", err, 1);

      // Reset during WAIT_DONE with words still queued.
      master_hold = 1'b1;
      push(8'h77, acc);
      push(8'h88, acc);
      push(8'h99, acc);
      wait_rdy("rm_start");
      step();
      rst = 1'b1;
      @(posedge clk);
      step();
      chk("rm_rdy", m_data_ready, 0);
      chk("rm_rx_valid", rx_valid, 0);
      chk("rm_err", err, 0);
      chk("rm_dout", m_data_out, 0);
      chk("rm_rx_data", rx_data, 0);
      chk("rm_in_ready", in_ready, 1);
      chk("rm_busy", busy, 0);
      rst = 1'b0;
      tx_q.delete();
      master_hold = 1'b0;
      repeat (4) begin
         step();
         chk("rm_no_tx", m_data_ready, 0);
      end

      // Recovery after reset.
      master_delay = 2;
      push(8'hC3, acc);
      chk("rec_acc", acc, 1);
      wait_idle("rec_done");
      chk("end_txq", tx_q.size(), 0);
      chk("end_rxq", rx_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
